seven_segment_scanner: RTL

Time-multiplexed driver for the 4-digit common-anode seven-segment display. Takes four hex/BCD nibbles plus decimal points and cycles through the digits at a fixed slot rate. It inserts a dead-time blank between slots to suppress ghosting and produces the active-low anode and segment vectors. `anode_out` feeds the anode input of the blink stage directly downstream; `seg_out`/`dp_out` go straight to the pins.

---
 rtl/seven_segment_scanner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 4-digit common-anode seven-segment scan driver with dead-time blanking
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
module seven_segment_scanner #(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [1:0]  digit_idx
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;

  logic          snap_edge;
  logic [15:0]   cur_digits;
  logic [3:0]    cur_dp;
  logic [3:0]    cur_nib;
  logic          in_blank;
  logic          lz_blank;
  logic [6:0]    drive_seg;
  logic [3:0]    drive_anode;
  logic          drive_dp;

  // Active-low gfedcba patterns for hex digits 0..F.
  function automatic logic [6:0] decode7(input logic [3:0] n);
    case (n)
      4'h0: decode7 = 7'h40;
      4'h1: decode7 = 7'h79;
      4'h2: decode7 = 7'h24;
      4'h3: decode7 = 7'h30;
      4'h4: decode7 = 7'h19;
      4'h5: decode7 = 7'h12;
      4'h6: decode7 = 7'h02;
      4'h7: decode7 = 7'h78;
      4'h8: decode7 = 7'h00;
      4'h9: decode7 = 7'h10;
      4'hA: decode7 = 7'h08;
      4'hB: decode7 = 7'h03;
      4'hC: decode7 = 7'h46;
      4'hD: decode7 = 7'h21;
      4'hE: decode7 = 7'h06;
      default: decode7 = 7'h0E;
    endcase
  endfunction

  // The first edge of slot 0 captures the frame; on that edge the live inputs
  // stand in for the snapshot so a zero-dead-time slot 0 shows the new frame.
  assign snap_edge  = (cnt == '0) && (digit_idx == 2'd0);
  assign cur_digits = snap_edge ? digits_in : snap_digits;
  assign cur_dp     = snap_edge ? dp_in : snap_dp;

  // Select the nibble belonging to the slot in progress.
  always_comb begin
    cur_nib = cur_digits[3:0];
    case (digit_idx)
      2'd1:    cur_nib = cur_digits[7:4];
      2'd2:    cur_nib = cur_digits[11:8];
      2'd3:    cur_nib = cur_digits[15:12];
      default: cur_nib = cur_digits[3:0];
    endcase
  end

  generate
    if (BLANK_CYCLES > 0) begin : g_dead
      localparam logic [CW-1:0] BLANK_L = CW'(BLANK_CYCLES);
      assign in_blank = (cnt < BLANK_L);
    end else begin : g_no_dead
      assign in_blank = 1'b0;
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (digit_idx)
      2'd1:    lz_blank = (cur_digits[15:4] == 12'h000);
      2'd2:    lz_blank = (cur_digits[15:8] == 8'h00);
      2'd3:    lz_blank = (cur_digits[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign drive_seg   = lz_blank ? 7'h7F : decode7(cur_nib);
  assign drive_anode = ~(4'b0001 << digit_idx);
  assign drive_dp    = ~cur_dp[digit_idx];

  // Slot counter, digit sequencer, frame snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      digit_idx   <= 2'd0;
      state       <= ST_BLANK;
      snap_digits <= 16'h0000;
      snap_dp     <= 4'h0;
      anode_out   <= 4'b1111;
      seg_out     <= 7'h7F;
      dp_out      <= 1'b1;
    end else if (!enable) begin
      cnt       <= '0;
      digit_idx <= 2'd0;
      state     <= ST_BLANK;
      anode_out <= 4'b1111;
      seg_out   <= 7'h7F;
      dp_out    <= 1'b1;
    end else begin
      if (snap_edge) begin
        snap_digits <= digits_in;
        snap_dp     <= dp_in;
      end
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (in_blank) begin
        state     <= ST_BLANK;
        anode_out <= 4'b1111;
        seg_out   <= 7'h7F;
        dp_out    <= 1'b1;
      end else begin
        state     <= ST_DRIVE;
        anode_out <= drive_anode;
        seg_out   <= drive_seg;
        dp_out    <= drive_dp;
      end
    end
  end

endmodule
